// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: walks an LDM/STM register list in ascending order, issuing
// one req/ack memory beat per set bit, then optionally writes back the base.
module ldm_stm_sequencer #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_load,
    input  logic              pre,
    input  logic              up,
    input  logic              writeback,
    input  logic [REG_AW-1:0] base_reg,
    input  logic [DATA_W-1:0] base_val,
    input  logic [15:0]       reg_list,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [REG_AW-1:0] reg_raddr,
    input  logic [DATA_W-1:0] reg_rdata,
    output logic              reg_we,
    output logic [REG_AW-1:0] reg_waddr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

    localparam logic [DATA_W-1:0] FOUR = DATA_W'(4);

    state_t            state, state_nxt;
    logic              ld_q, up_q, wb_q, hit_q;
    logic [REG_AW-1:0] breg_q;
    logic [DATA_W-1:0] base_q, span_q, addr_q;
    logic [15:0]       list_q, list_rest;
    logic [REG_AW-1:0] cur_reg;
    logic [4:0]        n_in;
    logic [DATA_W-1:0] span_in, start_addr;

    // Command decode: register count, byte span (4n) and first beat address
    always_comb begin
        n_in = '0;
        for (int i = 0; i < 16; i++) begin
            n_in = n_in + 5'(reg_list[i]);
        end
        span_in = DATA_W'({n_in, 2'b00});
        case ({pre, up})
            2'b01:   start_addr = base_val;
            2'b11:   start_addr = base_val + FOUR;
            2'b00:   start_addr = base_val - span_in + FOUR;
            default: start_addr = base_val - span_in;
        endcase
    end

    // Current register is the lowest remaining set bit; list_rest drops it
    always_comb begin
        cur_reg = '0;
        for (int i = 15; i >= 0; i--) begin
            if (list_q[i]) cur_reg = REG_AW'(i);
        end
        list_rest = list_q & (list_q - 16'd1);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Command latch and per-beat list/address advance
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_q   <= 1'b0;
            up_q   <= 1'b0;
            wb_q   <= 1'b0;
            hit_q  <= 1'b0;
            breg_q <= '0;
            base_q <= '0;
            span_q <= '0;
            addr_q <= '0;
            list_q <= '0;
        end else if (state == IDLE && start) begin
            ld_q   <= is_load;
            up_q   <= up;
            wb_q   <= writeback;
            hit_q  <= reg_list[base_reg];
            breg_q <= base_reg;
            base_q <= base_val;
            span_q <= span_in;
            addr_q <= start_addr;
            list_q <= reg_list;
        end else if (state == XFER && mem_ack) begin
            list_q <= list_rest;
            addr_q <= addr_q + FOUR;
        end
    end

    // Next state and all outputs; everything is zero outside its active state
    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        reg_raddr = '0;
        reg_we    = 1'b0;
        reg_waddr = '0;
        reg_wdata = '0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    if (n_in != 5'd0)   state_nxt = XFER;
                    else if (writeback) state_nxt = WB;
                    else                state_nxt = DONE;
                end
            end
            XFER: begin
                mem_req  = 1'b1;
                mem_we   = !ld_q;
                mem_addr = addr_q;
                if (!ld_q) begin
                    reg_raddr = cur_reg;
                    mem_wdata = reg_rdata;
                end
                if (mem_ack) begin
                    if (ld_q) begin
                        reg_we    = 1'b1;
                        reg_waddr = cur_reg;
                        reg_wdata = mem_rdata;
                    end
                    if (list_rest == 16'd0) state_nxt = wb_q ? WB : DONE;
                end
            end
            WB: begin
                // A loaded base register keeps the loaded value
                if (!(ld_q && hit_q)) begin
                    reg_we    = 1'b1;
                    reg_waddr = breg_q;
                    reg_wdata = up_q ? (base_q + span_q) : (base_q - span_q);
                end
                state_nxt = DONE;
            end
            default: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Bench for ldm_stm_sequencer: transaction-level model (expected beat queue,
// pending writeback, pending done) checked every cycle, plus literal pins.
module tb_ldm_stm_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, is_load, pre, up, writeback;
    logic [3:0]  base_reg;
    logic [31:0] base_val;
    logic [15:0] reg_list;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  reg_raddr, reg_waddr;
    logic [31:0] reg_rdata, reg_wdata;
    logic        reg_we, busy, done;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc, done_cyc;
    int reg_we_cnt, req_cnt;
    int stall_n = 0;
    int wait_cnt = 0;

    logic [31:0] rf [16];
    logic [31:0] smem [logic [31:0]];

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  r;
    } beat_t;
    beat_t       beats[$];
    bit          armed = 1'b0;
    bit          m_ld, m_wbp, m_wbwe, m_donep;
    logic [3:0]  m_breg;
    logic [31:0] m_wbval, ma;
    int          mn;

    ldm_stm_sequencer #(.DATA_W(32), .REG_AW(4)) dut (
        .clk(clk), .reset(reset), .start(start), .is_load(is_load), .pre(pre),
        .up(up), .writeback(writeback), .base_reg(base_reg), .base_val(base_val),
        .reg_list(reg_list), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .reg_raddr(reg_raddr), .reg_rdata(reg_rdata), .reg_we(reg_we),
        .reg_waddr(reg_waddr), .reg_wdata(reg_wdata), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rdfn(input logic [3:0] r);
        return 32'hC0DE_0000 | {28'd0, r};
    endfunction

    function automatic logic [31:0] ldfn(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Register file returns a tagged value; memory returns a tagged address
    assign reg_rdata = rdfn(reg_raddr);
    assign mem_rdata = ldfn(mem_addr);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Memory responder: ack after stall_n wait cycles per beat; ack idles high
    always @(posedge clk) begin
        #1;
        if (mem_req === 1'b1 && wait_cnt < stall_n) begin
            mem_ack = 1'b0;
            wait_cnt++;
        end else begin
            mem_ack = 1'b1;
            wait_cnt = 0;
        end
    end

    // Per-cycle compare against the model, then advance the model
    always @(negedge clk) begin
        if (armed) begin
            if (beats.size() > 0) begin
                chk("mem_req", mem_req, 1);
                chk("mem_we", mem_we, !m_ld);
                chk("mem_addr", mem_addr, beats[0].addr);
                chk("busy", busy, 1);
                chk("done", done, 0);
                if (m_ld) begin
                    chk("reg_we_ld", reg_we, mem_ack);
                    if (mem_ack) begin
                        chk("reg_waddr_ld", reg_waddr, beats[0].r);
                        chk("reg_wdata_ld", reg_wdata, ldfn(beats[0].addr));
                    end
                end else begin
                    chk("reg_raddr", reg_raddr, beats[0].r);
                    chk("mem_wdata", mem_wdata, rdfn(beats[0].r));
                    chk("reg_we_st", reg_we, 0);
                end
            end else if (m_wbp) begin
                chk("wb_reg_we", reg_we, m_wbwe);
                if (m_wbwe) begin
                    chk("wb_waddr", reg_waddr, m_breg);
                    chk("wb_wdata", reg_wdata, m_wbval);
                end
                chk("wb_mem_req", mem_req, 0);
                chk("wb_busy", busy, 1);
                chk("wb_done", done, 0);
            end else if (m_donep) begin
                chk("done_pulse", done, 1);
                chk("done_busy", busy, 1);
                chk("done_mem_req", mem_req, 0);
                chk("done_reg_we", reg_we, 0);
            end else begin
                chk("idle_busy", busy, 0);
                chk("idle_done", done, 0);
                chk("idle_mem_req", mem_req, 0);
                chk("idle_reg_we", reg_we, 0);
                chk("idle_mem_addr", mem_addr, 0);
                chk("idle_mem_wdata", mem_wdata, 0);
                chk("idle_reg_wdata", reg_wdata, 0);
            end
            if (reg_we === 1'b1) begin
                rf[reg_waddr] = reg_wdata;
                reg_we_cnt++;
            end
            if (mem_req === 1'b1) req_cnt++;
            if (mem_req === 1'b1 && mem_ack && mem_we === 1'b1) smem[mem_addr] = mem_wdata;
            if (done === 1'b1) done_cyc = cyc;
        end
        if (reset) begin
            beats.delete();
            m_wbp   = 1'b0;
            m_donep = 1'b0;
            armed   = 1'b1;
        end else if (armed) begin
            if (beats.size() > 0) begin
                if (mem_ack) void'(beats.pop_front());
            end else if (m_wbp) begin
                m_wbp = 1'b0;
            end else if (m_donep) begin
                m_donep = 1'b0;
            end else if (start) begin
                mn = $countones(reg_list);
                if (up) ma = pre ? base_val + 4 : base_val;
                else    ma = pre ? base_val - 4 * mn : base_val - 4 * mn + 4;
                for (int i = 0; i < 16; i++) begin
                    if (reg_list[i]) begin
                        beats.push_back('{ma, 4'(i)});
                        ma = ma + 4;
                    end
                end
                m_ld    = is_load;
                m_wbp   = writeback;
                m_wbwe  = !(is_load && reg_list[base_reg]);
                m_breg  = base_reg;
                m_wbval = up ? base_val + 4 * mn : base_val - 4 * mn;
                m_donep = 1'b1;
            end
        end
    end

    task automatic do_start(input bit ld, input bit p, input bit u, input bit w,
                            input logic [3:0] br, input logic [31:0] bv,
                            input logic [15:0] rl);
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) rf[i] = 32'h0;
        reg_we_cnt = 0;
        req_cnt    = 0;
        done_cyc   = -1;
        is_load = ld; pre = p; up = u; writeback = w;
        base_reg = br; base_val = bv; reg_list = rl;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        is_load = !ld; pre = !p; up = !u; writeback = !w;
        base_reg = ~br; base_val = 32'hDEAD_BEEF; reg_list = 16'hFFFF;
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (done_cyc < 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; is_load = 1'b0; pre = 1'b0; up = 1'b0;
        writeback = 1'b0; base_reg = '0; base_val = '0; reg_list = '0;
        mem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // LDMIA R0, {R1-R3} with writeback
        do_start(1, 0, 1, 1, 4'd0, 32'h100, 16'h000E);
        wait_done(50);
        chk("ldmia_r1", rf[1], 32'h5A5A_0100);
        chk("ldmia_r2", rf[2], 32'h5A5A_0104);
        chk("ldmia_r3", rf[3], 32'h5A5A_0108);
        chk("ldmia_wb", rf[0], 32'h0000_010C);
        chk("ldmia_lat", done_cyc - start_cyc, 5);
        chk("ldmia_wes", reg_we_cnt, 4);

        // STMDB R13, {R0,R15} with writeback
        do_start(0, 1, 0, 1, 4'd13, 32'h200, 16'h8001);
        wait_done(50);
        chk("stmdb_r0", smem.exists(32'h1F8) ? smem[32'h1F8] : 32'hFFFF_FFFF, 32'hC0DE_0000);
        chk("stmdb_r15", smem.exists(32'h1FC) ? smem[32'h1FC] : 32'hFFFF_FFFF, 32'hC0DE_000F);
        chk("stmdb_wb", rf[13], 32'h0000_01F8);
        chk("stmdb_lat", done_cyc - start_cyc, 4);

        // LDMIB R2, {R1,R2} with writeback: base in list, loaded value wins
        do_start(1, 1, 1, 1, 4'd2, 32'h300, 16'h0006);
        wait_done(50);
        chk("ldmib_r1", rf[1], 32'h5A5A_0304);
        chk("ldmib_r2", rf[2], 32'h5A5A_0308);
        chk("ldmib_wes", reg_we_cnt, 2);
        chk("ldmib_lat", done_cyc - start_cyc, 4);

        // Empty list, no writeback
        do_start(1, 0, 1, 0, 4'd3, 32'h700, 16'h0000);
        wait_done(50);
        chk("empty_reqs", req_cnt, 0);
        chk("empty_wes", reg_we_cnt, 0);
        chk("empty_lat", done_cyc - start_cyc, 1);

        // LDMDA R1, {R4,R7}, 3 wait cycles per beat, stray start mid-transfer
        stall_n = 3;
        do_start(1, 0, 0, 0, 4'd1, 32'h400, 16'h0090);
        repeat (2) @(posedge clk);
        #1 start = 1'b1; is_load = 1'b0; reg_list = 16'h00FF;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(100);
        chk("ldmda_r4", rf[4], 32'h5A5A_03FC);
        chk("ldmda_r7", rf[7], 32'h5A5A_0400);
        chk("ldmda_wes", reg_we_cnt, 2);
        chk("ldmda_reqs", req_cnt, 8);
        chk("ldmda_lat", done_cyc - start_cyc, 9);

        // Reset during the second beat of a 4-beat LDM
        stall_n = 2;
        do_start(1, 0, 1, 1, 4'd0, 32'h500, 16'h00F0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_reg_we", reg_we, 0);
        chk("rst_r4", rf[4], 32'h5A5A_0500);
        chk("rst_wes", reg_we_cnt, 1);

        // Fresh command after reset
        stall_n = 0;
        do_start(1, 0, 1, 0, 4'd9, 32'h600, 16'h0003);
        wait_done(50);
        chk("post_r0", rf[0], 32'h5A5A_0600);
        chk("post_r1", rf[1], 32'h5A5A_0604);
        chk("post_lat", done_cyc - start_cyc, 3);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
